reflet_delay_line: RTL and testbench

- Multi-bit, run-time-programmable delay line with per-sample valid tracking, flush and fill status.
- Parametrised successor to the single-bit fixed-delay shifter.
- Used in the GPU pipelines to align data buses with stages whose latency is configured at run time, e.g. memory read latency or rasteriser pipeline depth.
- Delay is chosen per cycle from 0..MAX_DELAY stages; stalls are supported via enable.

---
 rtl/reflet_delay_tap_mux.sv | 64 ++++++
 rtl/reflet_delay_line.sv | 100 ++++++++++
 tb/tb_reflet_delay_line.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/reflet_delay_tap_mux.sv
// reflet_delay_tap_mux
// Combinational tap selector for the delay line. It clamps the requested
// delay to MAX_DELAY and picks the {valid, data} pair of the matching stage.
// A delay of zero bypasses the stages and passes the live input straight
// through.
//
// Ports:
//   stages     flattened stage vector; stage i occupies bits
//              [i*(WIDTH+1) +: WIDTH+1] as {valid, data}
//   delay_sel  requested delay in enabled cycles (may exceed MAX_DELAY)
//   in         live input sample (used when the effective delay is 0)
//   in_valid   live input qualifier
//   eff_delay  effective delay, min(delay_sel, MAX_DELAY)
//   out        selected sample
//   out_valid  qualifier of the selected sample
module reflet_delay_tap_mux #(
    parameter int WIDTH     = 8,
    parameter int MAX_DELAY = 8,
    parameter int DSEL_W    = $clog2(MAX_DELAY + 1)
) (
    input  logic [MAX_DELAY*(WIDTH+1)-1:0] stages,
    input  logic [DSEL_W-1:0]              delay_sel,
    input  logic [WIDTH-1:0]               in,
    input  logic                           in_valid,
    output logic [DSEL_W-1:0]              eff_delay,
    output logic [WIDTH-1:0]               out,
    output logic                           out_valid
);

    localparam logic [DSEL_W-1:0] MAX_SEL = DSEL_W'(MAX_DELAY);

    logic [DSEL_W-1:0] eff_delay_s;
    logic [WIDTH:0]    tap_s;

    // Clamp the requested delay to the number of physical stages.
    always_comb begin
        eff_delay_s = delay_sel;
        if (delay_sel > MAX_SEL) begin
            eff_delay_s = MAX_SEL;
        end else begin
            eff_delay_s = delay_sel;
        end
    end

    // Select the tap: zero delay is a pure bypass, otherwise stage d-1 is
    // chosen by OR-ing the single matching stage into the result.
    always_comb begin
        tap_s = '0;
        if (eff_delay_s == '0) begin
            tap_s = {in_valid, in};
        end else begin
            for (int i = 0; i < MAX_DELAY; i++) begin
                tap_s = tap_s | ((eff_delay_s == DSEL_W'(i + 1))
                                 ? stages[i*(WIDTH+1) +: (WIDTH+1)]
                                 : {(WIDTH+1){1'b0}});
            end
        end
    end

    assign eff_delay = eff_delay_s;
    assign out       = tap_s[WIDTH-1:0];
    assign out_valid = tap_s[WIDTH];

endmodule

// File: rtl/reflet_delay_line.sv
// reflet_delay_line
// Run-time-programmable multi-bit delay line. Every enabled cycle the input
// sample and its valid bit shift into stage 0 and the oldest stage drops off.
// The output tap is chosen combinationally from the current delay_sel, so
// retuning the delay takes effect immediately without disturbing the stored
// history. Flush invalidates all stored samples (data bits are kept) and
// restarts the fill count; it wins over enable.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   enable     advance the line by one stage (stall when low)
//   flush      synchronous invalidate of all stored samples
//   delay_sel  requested delay, clamped to MAX_DELAY
//   in         input sample
//   in_valid   input sample qualifier
//   out        sample delayed by the effective delay
//   out_valid  qualifier of out
//   primed     fill count has reached the effective delay
module reflet_delay_line #(
    parameter int WIDTH     = 8,
    parameter int MAX_DELAY = 8,
    parameter int DSEL_W    = $clog2(MAX_DELAY + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              flush,
    input  logic [DSEL_W-1:0] delay_sel,
    input  logic [WIDTH-1:0]  in,
    input  logic              in_valid,
    output logic [WIDTH-1:0]  out,
    output logic              out_valid,
    output logic              primed
);

    localparam logic [DSEL_W-1:0] MAX_FILL = DSEL_W'(MAX_DELAY);

    logic [WIDTH-1:0]              data_r [MAX_DELAY];
    logic [MAX_DELAY-1:0]          valid_r;
    logic [DSEL_W-1:0]             fill_r;
    logic [MAX_DELAY*(WIDTH+1)-1:0] stage_flat_s;
    logic [DSEL_W-1:0]             eff_delay_s;

    // Stage shift register; flush clears only the valid bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= '0;
            for (int i = 0; i < MAX_DELAY; i++) begin
                data_r[i] <= '0;
            end
        end else if (flush) begin
            valid_r <= '0;
        end else if (enable) begin
            valid_r[0] <= in_valid;
            data_r[0]  <= in;
            for (int i = 1; i < MAX_DELAY; i++) begin
                valid_r[i] <= valid_r[i-1];
                data_r[i]  <= data_r[i-1];
            end
        end
    end

    // Saturating count of enabled cycles since reset or flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_r <= '0;
        end else if (flush) begin
            fill_r <= '0;
        end else if (enable && (fill_r != MAX_FILL)) begin
            fill_r <= fill_r + DSEL_W'(1);
        end
    end

    // Pack the stages as {valid, data} for the tap selector.
    always_comb begin
        stage_flat_s = '0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            stage_flat_s[i*(WIDTH+1) +: (WIDTH+1)] = {valid_r[i], data_r[i]};
        end
    end

    reflet_delay_tap_mux #(
        .WIDTH     (WIDTH),
        .MAX_DELAY (MAX_DELAY),
        .DSEL_W    (DSEL_W)
    ) u_tap_mux (
        .stages    (stage_flat_s),
        .delay_sel (delay_sel),
        .in        (in),
        .in_valid  (in_valid),
        .eff_delay (eff_delay_s),
        .out       (out),
        .out_valid (out_valid)
    );

    // With zero delay the fill count trivially satisfies the comparison.
    assign primed = (fill_r >= eff_delay_s);

endmodule

// File: tb/tb_reflet_delay_line.sv
// Self-checking bench for reflet_delay_line. The reference model keeps a log
// of every sample accepted on an enabled edge since the last reset, plus the
// log index where the current flush epoch begins. The expected output for a
// delay d is simply the entry d positions from the end of that log.
module tb_reflet_delay_line;

    localparam int WIDTH     = 8;
    localparam int MAX_DELAY = 8;
    localparam int DSEL_W    = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              flush;
    logic [DSEL_W-1:0] delay_sel;
    logic [WIDTH-1:0]  in;
    logic              in_valid;
    logic [WIDTH-1:0]  out;
    logic              out_valid;
    logic              primed;

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] data;
    } samp_t;

    typedef struct packed {
        logic [WIDTH-1:0] out;
        logic             ov;
        logic             pr;
    } exp_t;

    samp_t log_q[$];
    exp_t  exp_q[$];
    int    epoch       = 0;
    int    vectors     = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    reflet_delay_line #(
        .WIDTH     (WIDTH),
        .MAX_DELAY (MAX_DELAY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .flush     (flush),
        .delay_sel (delay_sel),
        .in        (in),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid),
        .primed    (primed)
    );

    // Expected outputs for the currently driven inputs and the model history.
    function automatic exp_t model_expect();
        exp_t e;
        int   d;
        int   idx;
        d = (int'(delay_sel) > MAX_DELAY) ? MAX_DELAY : int'(delay_sel);
        if (d == 0) begin
            e.out = in;
            e.ov  = in_valid;
            e.pr  = 1'b1;
        end else begin
            idx = log_q.size() - d;
            if (idx < 0) begin
                e.out = '0;
                e.ov  = 1'b0;
            end else begin
                e.out = log_q[idx].data;
                e.ov  = log_q[idx].v && (idx >= epoch);
            end
            e.pr = ((log_q.size() - epoch) >= d);
        end
        return e;
    endfunction

    // Drive one cycle of stimulus, queue its expectation, then update the model
    // with what the rising edge does.
    task automatic step(input logic rs, input logic en, input logic fl,
                        input logic [DSEL_W-1:0] ds, input logic [WIDTH-1:0] din,
                        input logic vin);
        samp_t s;
        @(negedge clk);
        #1;
        reset     = rs;
        enable    = en;
        flush     = fl;
        delay_sel = ds;
        in        = din;
        in_valid  = vin;
        if (rs) begin
            log_q.delete();
            epoch = 0;
        end
        exp_q.push_back(model_expect());
        @(posedge clk);
        #1;
        if (!rs) begin
            if (fl) begin
                epoch = log_q.size();
            end else if (en) begin
                s.v    = vin;
                s.data = din;
                log_q.push_back(s);
            end
        end
    endtask

    // Monitor: compare DUT outputs against queued expectations, mid low phase.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if ({out, out_valid, primed} !== {e.out, e.ov, e.pr}) begin
                    miscompares++;
                    $display("FAIL vec%0d: out=%h out_valid=%b primed=%b, expected out=%h out_valid=%b primed=%b",
                             vectors, out, out_valid, primed, e.out, e.ov, e.pr);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        reset = 1'b1; enable = 1'b0; flush = 1'b0;
        delay_sel = 4'd3; in = '0; in_valid = 1'b0;

        // Reset state with d>0
        step(1'b1, 1'b0, 1'b0, 4'd3, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b0, 4'd3, 8'h55, 1'b1);

        // Basic latency, delay 3
        for (int i = 1; i <= 12; i++) step(1'b0, 1'b1, 1'b0, 4'd3, 8'(i), 1'b1);

        // Stall with delay 2
        step(1'b0, 1'b1, 1'b0, 4'd2, 8'hA5, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 4'd2, 8'($urandom), 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 4'd2, 8'hB0 + 8'(i), 1'b1);

        // Flush priority over enable
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 4'd3, 8'h10 + 8'(i), 1'b1);
        step(1'b0, 1'b1, 1'b1, 4'd3, 8'h99, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 4'd3, 8'h20 + 8'(i), 1'b1);

        // Retune, clamp and bypass
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 4'd2, 8'(i), 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'd5,  8'h40, 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'd15, 8'h41, 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'd8,  8'h42, 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'd0,  8'h43, 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'd0,  8'h44, 1'b0);

        // Bubbles with delay 4
        step(1'b0, 1'b1, 1'b0, 4'd4, 8'h61, 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'd4, 8'h62, 1'b0);
        step(1'b0, 1'b1, 1'b0, 4'd4, 8'h63, 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'd4, 8'h64, 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'd4, 8'h65, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 4'd4, 8'h70 + 8'(i), 1'b1);

        // Async reset while full, then refill from empty
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 4'd3, 8'h80 + 8'(i), 1'b1);
        step(1'b1, 1'b1, 1'b0, 4'd3, 8'hEE, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 4'd3, 8'h90 + 8'(i), 1'b1);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 19) == 0),
                 4'($urandom_range(0, 15)),
                 8'($urandom),
                 1'($urandom_range(0, 3) != 0));
        end

        @(negedge clk);
        #5;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
